// File: rtl/fixed_bcd_pkg.sv
// Shared types for the fixed-point to BCD converter: FSM states, BCD nibble
// type and a constant log2 helper used to size counters.
package fixed_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INT,
        FRAC,
        FIN
    } state_t;

    typedef logic [3:0] bcd_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD nibble: digits of 5 or more get +3
// so the following left shift carries correctly into the next decade.
module bcd_add3_digit
    import fixed_bcd_pkg::*;
(
    input  bcd_t d_i,
    output bcd_t d_o
);

    assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/fixed_to_bcd_seq.sv
// Sequential unsigned fixed-point to packed BCD converter (double dabble for the
// integer part, multiply-by-10 for the fraction). FIXED_TO_BCD_ROUND_EN adds round-half-up.
//
// state | meaning
// IDLE  | waiting for start_i; outputs hold the last result
// INT   | one double-dabble shift per cycle, N cycles
// FRAC  | one fractional digit per cycle (plus a guard digit when rounding)
// FIN   | load output registers, pulse done_o
module fixed_to_bcd_seq
    import fixed_bcd_pkg::*;
#(
    parameter int N        = 32,
    parameter int DIGIT    = 16,
    parameter int INT_DIG  = 10,
    parameter int FRAC_DIG = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [N+DIGIT-1:0]    data_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*INT_DIG-1:0]  int_bcd_o,
    output logic [4*FRAC_DIG-1:0] frac_bcd_o,
    output logic                  overflow_o
);

`ifdef FIXED_TO_BCD_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int FSTEPS = FRAC_DIG + RND;
    localparam int CMAX   = (N > FSTEPS) ? N : FSTEPS;
    localparam int CW     = clog2(CMAX + 1);
    localparam int IW     = 4 * INT_DIG;
    localparam int FW     = 4 * FRAC_DIG;
    localparam int WW     = 4 * FSTEPS;

    state_t            state_q;
    logic [N-1:0]      int_sr_q;
    logic [IW-1:0]     bcd_q;
    logic              ovf_r_q;
    logic [DIGIT-1:0]  frac_r_q;
    logic [WW-1:0]     fwork_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [IW-1:0]     int_bcd_q;
    logic [FW-1:0]     frac_bcd_q;
    logic              overflow_q;

    logic [IW-1:0]     bcd_adj;
    logic [IW-1:0]     bcd_shift_d;
    logic [DIGIT+3:0]  prod_d;
    logic [WW-1:0]     fwork_d;
    logic [IW-1:0]     int_fin_d;
    logic [FW-1:0]     frac_fin_d;
    logic              ovf_fin_d;

    for (genvar g = 0; g < INT_DIG; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .d_i (bcd_q[4*g +: 4]),
            .d_o (bcd_adj[4*g +: 4])
        );
    end

    assign bcd_shift_d = {bcd_adj[IW-2:0], int_sr_q[N-1]};
    assign prod_d      = {4'b0, frac_r_q} * (DIGIT+4)'(10);
    assign fwork_d     = (fwork_q << 4) | WW'(prod_d[DIGIT+3:DIGIT]);

`ifdef FIXED_TO_BCD_ROUND_EN
    logic carry;

    // Guard digit sits in the low nibble; ripple +1 through fraction then integer.
    always_comb begin
        int_fin_d  = bcd_q;
        frac_fin_d = fwork_q[WW-1 -: FW];
        ovf_fin_d  = ovf_r_q;
        carry      = (fwork_q[3:0] >= 4'd5);
        for (int i = 0; i < FRAC_DIG; i++) begin
            if (carry) begin
                if (frac_fin_d[4*i +: 4] == 4'd9) begin
                    frac_fin_d[4*i +: 4] = 4'd0;
                end else begin
                    frac_fin_d[4*i +: 4] = frac_fin_d[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        for (int i = 0; i < INT_DIG; i++) begin
            if (carry) begin
                if (int_fin_d[4*i +: 4] == 4'd9) begin
                    int_fin_d[4*i +: 4] = 4'd0;
                end else begin
                    int_fin_d[4*i +: 4] = int_fin_d[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (carry) ovf_fin_d = 1'b1;
    end
`else
    always_comb begin
        int_fin_d  = bcd_q;
        frac_fin_d = fwork_q[WW-1 -: FW];
        ovf_fin_d  = ovf_r_q;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            int_sr_q   <= '0;
            bcd_q      <= '0;
            ovf_r_q    <= 1'b0;
            frac_r_q   <= '0;
            fwork_q    <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            int_bcd_q  <= '0;
            frac_bcd_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // The done cycle is spent in IDLE, so it must block a new start itself.
                    if (start_i && !done_q) begin
                        int_sr_q <= data_i[N+DIGIT-1:DIGIT];
                        frac_r_q <= data_i[DIGIT-1:0];
                        bcd_q    <= '0;
                        ovf_r_q  <= 1'b0;
                        fwork_q  <= '0;
                        cnt_q    <= CW'(N);
                        busy_q   <= 1'b1;
                        state_q  <= INT;
                    end
                end
                INT: begin
                    bcd_q    <= bcd_shift_d;
                    int_sr_q <= int_sr_q << 1;
                    ovf_r_q  <= ovf_r_q | bcd_adj[IW-1];
                    if (cnt_q == CW'(1)) begin
                        cnt_q   <= CW'(FSTEPS);
                        state_q <= FRAC;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FRAC: begin
                    frac_r_q <= prod_d[DIGIT-1:0];
                    fwork_q  <= fwork_d;
                    if (cnt_q == CW'(1)) begin
                        cnt_q   <= '0;
                        state_q <= FIN;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                FIN: begin
                    int_bcd_q  <= int_fin_d;
                    frac_bcd_q <= frac_fin_d;
                    overflow_q <= ovf_fin_d;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign int_bcd_o  = int_bcd_q;
    assign frac_bcd_o = frac_bcd_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fixed_to_bcd_seq.sv
// Self-checking bench for fixed_to_bcd_seq: decimal reference model with random
// and directed stimulus, two instances (INT_DIG=10 and INT_DIG=9).
module tb_fixed_to_bcd_seq;

`ifdef FIXED_TO_BCD_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int LAT = 32 + 4 + 1 + RND;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start9;
    logic [47:0] data_a, data9;
    logic        busy_a, done_a, ovf_a;
    logic        busy9, done9, ovf9;
    logic [39:0] int_a;
    logic [35:0] int9;
    logic [15:0] frac_a, frac9;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fixed_to_bcd_seq #(.N(32), .DIGIT(16), .INT_DIG(10), .FRAC_DIG(4)) dut_a (
        .clk_i(clk), .rst_i(rst_n), .start_i(start_a), .data_i(data_a),
        .busy_o(busy_a), .done_o(done_a), .int_bcd_o(int_a),
        .frac_bcd_o(frac_a), .overflow_o(ovf_a));

    fixed_to_bcd_seq #(.N(32), .DIGIT(16), .INT_DIG(9), .FRAC_DIG(4)) dut_9 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start9), .data_i(data9),
        .busy_o(busy9), .done_o(done9), .int_bcd_o(int9),
        .frac_bcd_o(frac9), .overflow_o(ovf9));

    function automatic logic [39:0] to_bcd(input longint unsigned v, input int nd);
        logic [39:0] r;
        r = '0;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Decimal reference: value scaled by 10^4, plus one for round-half-up on the 5th digit.
    task automatic model(input logic [47:0] d, input int id, output logic [39:0] ib,
                         output logic [15:0] fb, output bit ov);
        longint unsigned iv, f, fn, tot, lim;
        logic [39:0] tmp;
        int rd;
        iv = 64'(d[47:16]);
        f  = 64'(d[15:0]);
        fn = 0;
        rd = 0;
        for (int k = 0; k < 4; k++) begin
            f  = f * 10;
            fn = fn * 10 + (f >> 16);
            f  = f & 64'hFFFF;
        end
        if (RND == 1) begin
            f  = f * 10;
            rd = int'(f >> 16);
        end
        lim = 1;
        for (int k = 0; k < id; k++) lim = lim * 10;
        tot = iv * 10000 + fn + ((rd >= 5) ? 64'd1 : 64'd0);
        ov  = (tot >= lim * 10000);
        ib  = to_bcd(tot / 10000, 10);
        tmp = to_bcd(tot % 10000, 4);
        fb  = tmp[15:0];
    endtask

    // Issues one start and waits for done; lat=-1 if done never comes.
    task automatic conv(input bit sel9, input logic [47:0] d, output int lat);
        @(posedge clk); #1;
        if (sel9) begin start9 = 1'b1; data9 = d; end
        else begin start_a = 1'b1; data_a = d; end
        @(posedge clk); #1;
        start_a = 1'b0;
        start9  = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if ((sel9 ? done9 : done_a) === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 1'b1; data_a = 48'h1234_5678_9ABC;
        start9 = 1'b0;  data9 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 5;
        if (busy_a !== 1'b0) begin n_mis++; $display("FAIL reset_busy got %b want 0", busy_a); end
        if (done_a !== 1'b0) begin n_mis++; $display("FAIL reset_done got %b want 0", done_a); end
        if (ovf_a !== 1'b0) begin n_mis++; $display("FAIL reset_ovf got %b want 0", ovf_a); end
        if (int_a !== 40'h0) begin n_mis++; $display("FAIL reset_int got %h want 0", int_a); end
        if (frac_a !== 16'h0) begin n_mis++; $display("FAIL reset_frac got %h want 0", frac_a); end
        start_a = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [47:0] vec [5];
        logic [39:0] eib;
        logic [15:0] efb;
        bit eov;
        int lat;
        vec[0] = 48'h0000_0003_8000;
        vec[1] = 48'hFFFF_FFFF_5555;
        vec[2] = 48'h0000_0007_FFFF;
        vec[3] = 48'h0000_0000_0000;
        vec[4] = 48'h0000_0001_0001;
        for (int i = 0; i < 5; i++) begin
            model(vec[i], 10, eib, efb, eov);
            conv(1'b0, vec[i], lat);
            n_cmp += 5;
            if (lat !== LAT) begin n_mis++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT); end
            if (int_a !== eib) begin n_mis++; $display("FAIL dir%0d_int got %h want %h", i, int_a, eib); end
            if (frac_a !== efb) begin n_mis++; $display("FAIL dir%0d_frac got %h want %h", i, frac_a, efb); end
            if (ovf_a !== eov) begin n_mis++; $display("FAIL dir%0d_ovf got %b want %b", i, ovf_a, eov); end
            if (busy_a !== 1'b0) begin n_mis++; $display("FAIL dir%0d_busy_at_done got %b want 0", i, busy_a); end
            if (i == 0) begin
                n_cmp += 2;
                if (int_a !== 40'h0000000003) begin n_mis++; $display("FAIL c3p5_int got %h want 0000000003", int_a); end
                if (frac_a !== 16'h5000) begin n_mis++; $display("FAIL c3p5_frac got %h want 5000", frac_a); end
            end
            if (i == 1) begin
                n_cmp += 2;
                if (int_a !== 40'h4294967295) begin n_mis++; $display("FAIL cmax_int got %h want 4294967295", int_a); end
                if (frac_a !== 16'h3333) begin n_mis++; $display("FAIL cmax_frac got %h want 3333", frac_a); end
            end
            if (i == 2) begin
                n_cmp += 2;
                if (int_a !== ((RND == 1) ? 40'h8 : 40'h7)) begin n_mis++; $display("FAIL c7p99_int got %h", int_a); end
                if (frac_a !== ((RND == 1) ? 16'h0000 : 16'h9999)) begin n_mis++; $display("FAIL c7p99_frac got %h", frac_a); end
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done_a !== 1'b0) begin n_mis++; $display("FAIL dir%0d_done_width got %b want 0", i, done_a); end
        end
    endtask

    task automatic test_random();
        logic [47:0] d;
        logic [39:0] eib;
        logic [15:0] efb;
        bit eov;
        int lat;
        for (int i = 0; i < 30; i++) begin
            d[47:16] = (i % 3 == 0) ? 32'($urandom_range(0, 999)) : 32'($urandom);
            d[15:0]  = 16'($urandom);
            model(d, 10, eib, efb, eov);
            conv(1'b0, d, lat);
            n_cmp += 4;
            if (lat !== LAT) begin n_mis++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, LAT); end
            if (int_a !== eib) begin n_mis++; $display("FAIL rnd%0d_int d=%h got %h want %h", i, d, int_a, eib); end
            if (frac_a !== efb) begin n_mis++; $display("FAIL rnd%0d_frac d=%h got %h want %h", i, d, frac_a, efb); end
            if (ovf_a !== eov) begin n_mis++; $display("FAIL rnd%0d_ovf got %b want %b", i, ovf_a, eov); end
        end
    endtask

    task automatic test_overflow();
        logic [47:0] vec [8];
        logic [39:0] eib;
        logic [15:0] efb;
        bit eov;
        int lat;
        vec[0] = {32'd1000000000, 16'h0000};
        vec[1] = {32'd999999999, 16'h0000};
        vec[2] = {32'd999999999, 16'hFFFF};
        vec[3] = {32'hFFFF_FFFF, 16'h1234};
        for (int i = 4; i < 8; i++) vec[i] = {32'($urandom_range(0, 1999999999)), 16'($urandom)};
        for (int i = 0; i < 8; i++) begin
            model(vec[i], 9, eib, efb, eov);
            conv(1'b1, vec[i], lat);
            n_cmp += 2;
            if (lat !== LAT) begin n_mis++; $display("FAIL ovf%0d_latency got %0d want %0d", i, lat, LAT); end
            if (ovf9 !== eov) begin n_mis++; $display("FAIL ovf%0d_flag d=%h got %b want %b", i, vec[i], ovf9, eov); end
            if (i == 0) begin
                n_cmp++;
                if (ovf9 !== 1'b1) begin n_mis++; $display("FAIL ovf_1e9 got %b want 1", ovf9); end
            end
            if (!eov) begin
                n_cmp += 2;
                if ({4'h0, int9} !== eib) begin n_mis++; $display("FAIL ovf%0d_int got %h want %h", i, int9, eib); end
                if (frac9 !== efb) begin n_mis++; $display("FAIL ovf%0d_frac got %h want %h", i, frac9, efb); end
            end
        end
    endtask

    task automatic test_abort();
        logic [47:0] d2;
        logic [39:0] eib;
        logic [15:0] efb;
        bit eov;
        int lat, dones;
        @(posedge clk); #1;
        start_a = 1'b1; data_a = 48'h0000_1234_4000;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp += 5;
        if (busy_a !== 1'b0) begin n_mis++; $display("FAIL abort_busy got %b want 0", busy_a); end
        if (done_a !== 1'b0) begin n_mis++; $display("FAIL abort_done got %b want 0", done_a); end
        if (int_a !== 40'h0) begin n_mis++; $display("FAIL abort_int got %h want 0", int_a); end
        if (frac_a !== 16'h0) begin n_mis++; $display("FAIL abort_frac got %h want 0", frac_a); end
        if (ovf_a !== 1'b0) begin n_mis++; $display("FAIL abort_ovf got %b want 0", ovf_a); end
        rst_n = 1'b1;
        dones = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin n_mis++; $display("FAIL abort_no_done got %0d want 0", dones); end
        d2 = 48'h0000_0042_C000;
        model(d2, 10, eib, efb, eov);
        conv(1'b0, d2, lat);
        n_cmp += 3;
        if (lat !== LAT) begin n_mis++; $display("FAIL abort_fresh_latency got %0d want %0d", lat, LAT); end
        if (int_a !== eib) begin n_mis++; $display("FAIL abort_fresh_int got %h want %h", int_a, eib); end
        if (frac_a !== efb) begin n_mis++; $display("FAIL abort_fresh_frac got %h want %h", frac_a, efb); end
    endtask

    task automatic test_ignore_start();
        logic [47:0] d1, d2;
        logic [39:0] eib, cap_i;
        logic [15:0] efb, cap_f;
        bit eov;
        int dones;
        d1 = {32'($urandom_range(1, 99999)), 16'($urandom)};
        d2 = {32'($urandom_range(100000, 9999999)), 16'($urandom)};
        model(d1, 10, eib, efb, eov);
        @(posedge clk); #1;
        start_a = 1'b1; data_a = d1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start_a = 1'b1; data_a = d2;
        @(posedge clk); #1;
        start_a = 1'b0;
        n_cmp++;
        if (busy_a !== 1'b1) begin n_mis++; $display("FAIL ign_busy got %b want 1", busy_a); end
        dones = 0;
        cap_i = '0;
        cap_f = '0;
        repeat (80) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) begin dones++; cap_i = int_a; cap_f = frac_a; end
        end
        n_cmp += 3;
        if (dones !== 1) begin n_mis++; $display("FAIL ign_done_count got %0d want 1", dones); end
        if (cap_i !== eib) begin n_mis++; $display("FAIL ign_int got %h want %h", cap_i, eib); end
        if (cap_f !== efb) begin n_mis++; $display("FAIL ign_frac got %h want %h", cap_f, efb); end
    endtask

    task automatic test_done_start();
        logic [47:0] d1;
        logic [39:0] eib;
        logic [15:0] efb;
        bit eov;
        int lat, dones;
        d1 = 48'h0000_0063_2000;
        model(d1, 10, eib, efb, eov);
        conv(1'b0, d1, lat);
        start_a = 1'b1; data_a = 48'h0000_0005_0000;
        @(posedge clk); #1;
        start_a = 1'b0;
        n_cmp += 2;
        if (lat !== LAT) begin n_mis++; $display("FAIL ds_latency got %0d want %0d", lat, LAT); end
        if (busy_a !== 1'b0) begin n_mis++; $display("FAIL ds_busy got %b want 0", busy_a); end
        dones = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done_a === 1'b1) dones++;
        end
        n_cmp += 3;
        if (dones !== 0) begin n_mis++; $display("FAIL ds_no_done got %0d want 0", dones); end
        if (int_a !== eib) begin n_mis++; $display("FAIL ds_hold_int got %h want %h", int_a, eib); end
        if (frac_a !== efb) begin n_mis++; $display("FAIL ds_hold_frac got %h want %h", frac_a, efb); end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; start9 = 1'b0;
        data_a = '0; data9 = '0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_overflow();
        test_abort();
        test_ignore_start();
        test_done_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/fixed_to_bcd_seq.md
Name: fixed_to_bcd_seq

Overview:
- Sequential converter that sits directly downstream of the fixed-point divider.
- Takes the unsigned quotient (N integer bits, DIGIT fractional bits) when the divider signals completion.
- Produces packed BCD integer and fractional digits for the display/UART formatting stage.
- Integer part uses shift-add-3 (double dabble). Fractional part uses repeated multiply-by-10. Result is delivered with a done pulse.

Parameters:
- N, 32: integer bit width of the input.
- DIGIT, 16: fractional bit width of the input.
- INT_DIG, 10: number of BCD integer digits produced.
- FRAC_DIG, 4: number of BCD fractional digits produced (1..DIGIT).

Ports:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle request; data_i is valid in the same cycle.
- data_i  in  N+DIGIT  unsigned fixed point; bits [DIGIT-1:0] are the fraction.
- busy_o  out  1  high from the cycle after start is accepted until done_o.
- done_o  out  1  one-cycle pulse; BCD outputs are valid from this cycle on.
- int_bcd_o  out  4*INT_DIG  integer digits, most significant digit in the top nibble.
- frac_bcd_o  out  4*FRAC_DIG  fractional digits, first digit after the point in the top nibble.
- overflow_o  out  1  integer value does not fit in INT_DIG digits; valid with done_o.

Behaviour:
- Reset: one of these two conditions, sampled at a clock edge, resets the block:
  - rst_i=0 at the edge, or
  - the block is in any state when rst_i=0.
- On reset: state goes to IDLE; busy_o=0, done_o=0, overflow_o=0; int_bcd_o and frac_bcd_o are all zeros; all counters are cleared.
- Reset mid-conversion aborts the conversion immediately. No done_o is produced.
- States: IDLE, INT, FRAC, FIN.
- IDLE:
  - start_i=1 at edge E0 latches data_i.
  - Integer bits go into the shift register; the BCD working register is cleared; the fraction goes into frac_r.
  - Move to INT with bit counter = N.
- INT, one input bit per edge (E1..EN):
  - Every BCD nibble ≥5 gets +3.
  - Then shift left by one, bringing in the MSB of the integer register.
  - A 1 shifted out of the top nibble sets a sticky ovf_r.
  - After N shifts, move to FRAC.
- FRAC, one digit per edge (E(N+1)..E(N+FRAC_DIG)):
  - prod = frac_r*10, computed in DIGIT+4 bits.
  - The next digit is prod[DIGIT+3:DIGIT]; frac_r takes prod[DIGIT-1:0].
  - The default result is truncated: no rounding.
- FIN:
  - At the next edge, the output registers load the working values, done_o=1 for exactly one cycle, busy_o=0, and the state returns to IDLE.
  - Default latency: done_o is high N+FRAC_DIG+1 cycles after the E0 edge.
- Outputs hold their last value until the next FIN or a reset.
- start_i while busy_o=1 is ignored; no queueing.
- start_i in the same cycle as done_o is ignored. A new start is accepted only in IDLE, i.e. one cycle after done_o.
- Data equal to 0 gives all-zero digits and overflow_o=0.

Optional Feature:
- Macro: FIXED_TO_BCD_ROUND_EN.
- Defined:
  - One extra FRAC step computes digit FRAC_DIG+1.
  - If that digit is ≥5, 1 is added to the full BCD value (fraction digits, then integer digits, with a decimal carry chain).
  - A carry out of the top integer digit sets overflow_o.
  - Latency becomes N+FRAC_DIG+2.
- Undefined: truncation, with latency as stated above.

Decomposition:
- Package fixed_bcd_pkg holds:
  - the state enum typedef (IDLE, INT, FRAC, FIN);
  - the BCD nibble typedef;
  - localparam function clog2 for the counter width.
- Sub-module bcd_add3_digit: combinational nibble ≥5 → +3 correction, instantiated INT_DIG times via generate.

Test Plan (N=32, DIGIT=16 unless stated):
- 3.5 (data_i=0x0000_0003_8000), start → done_o at cycle E0+37; int_bcd_o=0x0000000003, frac_bcd_o=0x5000, overflow_o=0.
- data_i=0xFFFF_FFFF_5555 → int_bcd_o=0x4294967295, frac_bcd_o=0x3333, overflow_o=0.
- INT_DIG=9, integer part 1_000_000_000 → overflow_o=1 with done_o.
- Start, then rst_i=0 at E10 → next cycle busy_o=0, outputs zero, no done_o; a fresh start converts correctly.
- start_i pulsed again at E5 with different data → ignored; the result matches the first data only, with a single done_o.
- With FIXED_TO_BCD_ROUND_EN, data 7.99998 (0x0000_0007_FFFF) → int_bcd_o=...0008, frac_bcd_o=0x0000, done_o at E0+38. Without the macro → 0x...0007 / 0x9999.
